// File: rtl/gst_snd_pkg.sv
// Shared types and default sizes for the sound DMA engine.
// Imported by gst_snd_dma and gst_snd_fifo.
package gst_snd_pkg;

  localparam int SND_ADDR_W     = 22;
  localparam int SND_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } snd_state_e;

endpackage

// File: rtl/gst_snd_fifo.sv
// DEPTH x W word buffer: head word readable combinationally, count updates one cycle after push/pop.
// Push is dropped when full and pop when empty; flush empties it on the next edge.
module gst_snd_fifo
  import gst_snd_pkg::*;
#(
  parameter int DEPTH = SND_FIFO_DEPTH,
  parameter int W     = 16
) (
  input  logic                   c,
  input  logic                   xr,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_q];
  assign do_push    = push_i && !flush_i && (cnt_q != (AW+1)'(DEPTH));
  assign do_pop     = pop_i && !flush_i && !empty_o;

  always_ff @(posedge c) begin
    if (!xr || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: only words between rd_q and wr_q are ever read.
  always_ff @(posedge c) begin
    if (xr && do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/gst_snd_dma.sv
// Sound DMA: one outstanding word fetch at a time into a FIFO, samples update 1 cycle after smp_tick,
// fetch stalls while the FIFO is full. Mono byte-phase playback exists only with GSTMCU_SND_MONO_EN.
module gst_snd_dma
  import gst_snd_pkg::*;
#(
  parameter int ADDR_W     = SND_ADDR_W,
  parameter int FIFO_DEPTH = SND_FIFO_DEPTH
) (
  input  logic              c,
  input  logic              xr,
  input  logic              snd_en,
  input  logic              snd_loop,
  input  logic              mono,
  input  logic [ADDR_W-1:0] frame_start,
  input  logic [ADDR_W-1:0] frame_end,
  input  logic              smp_tick,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_ack,
  input  logic [15:0]       dma_data,
  output logic [7:0]        sample_l,
  output logic [7:0]        sample_r,
  output logic              snd_int,
  output logic [ADDR_W-1:0] cnt_addr,
  output logic              active
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  snd_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cnt_inc;
  logic              en_q;
  logic              int_q;
  logic [7:0]        smp_l_q;
  logic [7:0]        smp_r_q;

  logic [15:0]       head_dat;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              ack_ok;
  logic              tick_ok;
  logic              fifo_pop;
  logic              phase_busy;

  assign cnt_inc = cnt_q + 1'b1;

  // Request depends only on registered state, so it holds steady until the ack.
  assign dma_req = (state_q == ST_RUN) && (fifo_cnt < CW'(FIFO_DEPTH)) && (cnt_q != end_q);
  assign ack_ok  = dma_req && dma_ack && snd_en;
  assign tick_ok = snd_en && smp_tick && !fifo_empty &&
                   ((state_q == ST_RUN) || (state_q == ST_DRAIN));

`ifdef GSTMCU_SND_MONO_EN
  logic phase_q;
  assign phase_busy = phase_q;
  assign fifo_pop   = tick_ok && (!mono || phase_q);
`else
  logic mono_unused;
  assign mono_unused = mono;
  assign phase_busy  = 1'b0;
  assign fifo_pop    = tick_ok;
`endif

  gst_snd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .c          (c),
    .xr         (xr),
    .flush_i    (!snd_en),
    .push_i     (ack_ok),
    .push_dat_i (dma_data),
    .pop_i      (fifo_pop),
    .head_dat_o (head_dat),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge c) begin
    if (!xr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      end_q   <= '0;
      en_q    <= 1'b0;
      int_q   <= 1'b0;
      smp_l_q <= '0;
      smp_r_q <= '0;
`ifdef GSTMCU_SND_MONO_EN
      phase_q <= 1'b0;
`endif
    end else begin
      en_q  <= snd_en;
      int_q <= 1'b0;
      if (!snd_en) begin
        state_q <= ST_IDLE;
        smp_l_q <= '0;
        smp_r_q <= '0;
`ifdef GSTMCU_SND_MONO_EN
        phase_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!en_q) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            cnt_q <= frame_start;
            end_q <= frame_end;
            if (frame_start == frame_end) begin
              int_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (ack_ok) begin
              if (cnt_inc == end_q) begin
                int_q <= 1'b1;
                if (snd_loop) begin
                  cnt_q <= frame_start;
                  end_q <= frame_end;
                end else begin
                  cnt_q   <= cnt_inc;
                  state_q <= ST_DRAIN;
                end
              end else begin
                cnt_q <= cnt_inc;
              end
            end
          end
          ST_DRAIN: begin
            if (fifo_empty && !phase_busy) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase

        if (tick_ok) begin
`ifdef GSTMCU_SND_MONO_EN
          // Mono: high byte first, low byte on the following tick, then the word retires.
          if (mono) begin
            smp_l_q <= phase_q ? head_dat[7:0] : head_dat[15:8];
            smp_r_q <= phase_q ? head_dat[7:0] : head_dat[15:8];
            phase_q <= !phase_q;
          end else begin
            smp_l_q <= head_dat[15:8];
            smp_r_q <= head_dat[7:0];
            phase_q <= 1'b0;
          end
`else
          smp_l_q <= head_dat[15:8];
          smp_r_q <= head_dat[7:0];
`endif
        end
      end
    end
  end

  assign dma_addr = cnt_q;
  assign cnt_addr = cnt_q;
  assign sample_l = smp_l_q;
  assign sample_r = smp_r_q;
  assign snd_int  = int_q;
  assign active   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gst_snd_dma.sv
// Self-checking bench for gst_snd_dma: directed sequences, a frame table and randomized frames
// scored against a word-queue model of the playback stream.
module tb_gst_snd_dma;

  logic        c = 1'b0;
  logic        xr = 1'b0;
  logic        snd_en = 1'b0;
  logic        snd_loop = 1'b0;
  logic        mono = 1'b0;
  logic [21:0] frame_start = '0;
  logic [21:0] frame_end = '0;
  logic        smp_tick = 1'b0;
  logic        dma_req;
  logic [21:0] dma_addr;
  logic        dma_ack = 1'b0;
  logic [15:0] dma_data = '0;
  logic [7:0]  sample_l;
  logic [7:0]  sample_r;
  logic        snd_int;
  logic [21:0] cnt_addr;
  logic        active;

  gst_snd_dma #(.ADDR_W(22), .FIFO_DEPTH(4)) dut (
    .c(c), .xr(xr), .snd_en(snd_en), .snd_loop(snd_loop), .mono(mono),
    .frame_start(frame_start), .frame_end(frame_end), .smp_tick(smp_tick),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_data(dma_data),
    .sample_l(sample_l), .sample_r(sample_r), .snd_int(snd_int),
    .cnt_addr(cnt_addr), .active(active)
  );

  always #5 c = ~c;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus model and playback model state
  int          lat = 2;
  bit          pending = 0;
  int          wcnt = 0;
  bit          fixed = 0;
  logic [15:0] fixed_val = '0;
  logic [21:0] cur_end = '0;
  bit          model_on = 0;
  int          acks = 0;
  int          ints = 0;
  int          pops = 0;
  logic [21:0] ack_log[$];
  logic [15:0] words_q[$];

  typedef struct {
    logic [21:0] s;
    logic [21:0] e;
    int          lat;
    int          n;
    int          ni;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memw(input logic [21:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] ^ a[7:0] ^ 8'h3C};
  endfunction

  task automatic model_clear();
    acks = 0; ints = 0; pops = 0;
    ack_log.delete();
    words_q.delete();
  endtask

  // One clock: inputs were set after the previous edge; outputs are sampled 1ns after this edge.
  task automatic step();
    bit          eff;
    bit          had_ack;
    bit          exp_int;
    logic [15:0] w;
    eff     = xr && snd_en && smp_tick && ((words_q.size() - pops - (dma_ack ? 1 : 0)) > 0);
    had_ack = dma_ack;
    exp_int = dma_ack && snd_en && ((dma_addr + 22'd1) == cur_end);
    @(posedge c);
    #1;
    if (snd_int) ints++;
    if (had_ack) chk("snd_int_after_ack", 32'(snd_int), 32'(exp_int));
    if (model_on && eff) begin
      w = words_q[pops];
      chk("sample_l", 32'(sample_l), 32'(w[15:8]));
      chk("sample_r", 32'(sample_r), 32'(w[7:0]));
      pops++;
    end
    if (dma_ack) begin
      dma_ack = 1'b0;
      pending = 0;
    end
    if (pending && !dma_req) pending = 0;
    if (dma_req && !pending) begin
      pending = 1;
      wcnt = lat;
    end
    if (pending) begin
      if (wcnt == 0) begin
        dma_ack  = 1'b1;
        dma_data = fixed ? fixed_val : memw(dma_addr);
        ack_log.push_back(dma_addr);
        words_q.push_back(dma_data);
        acks++;
        chk("fifo_bound", 32'((words_q.size() - pops) <= 4), 32'd1);
      end else begin
        wcnt--;
      end
    end
  endtask

  task automatic stop_play();
    snd_en = 1'b0;
    smp_tick = 1'b0;
    step();
    step();
  endtask

  task automatic wait_ack(input logic [21:0] a);
    int g;
    g = 0;
    while (!(dma_ack && dma_addr == a) && g < 100) begin
      step();
      g++;
    end
    chk("ack_seen", 32'(dma_ack && dma_addr == a), 32'd1);
  endtask

  task automatic run_frame(input logic [21:0] s, input logic [21:0] e, input int l,
                           input int exp_n, input int exp_ni);
    int          g;
    logic [21:0] ea;
    stop_play();
    model_clear();
    model_on = 1; fixed = 0; mono = 1'b0; snd_loop = 1'b0; lat = l;
    frame_start = s; frame_end = e; cur_end = e;
    snd_en = 1'b1;
    step();
    g = 0;
    while (active && g < 600) begin
      smp_tick = ($urandom_range(0, 2) == 0);
      step();
      g++;
    end
    smp_tick = 1'b0;
    chk("frame_done", 32'(active), 32'd0);
    chk("n_req", 32'(acks), 32'(exp_n));
    for (int k = 0; k < acks && k < exp_n; k++) begin
      ea = s + 22'(k);
      chk("req_addr", 32'(ack_log[k]), 32'(ea));
    end
    chk("n_int", 32'(ints), 32'(exp_ni));
    chk("played", 32'(pops), 32'(exp_n));
    chk("cnt_end", 32'(cnt_addr), 32'(e));
    chk("req_idle", 32'(dma_req), 32'd0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] w;
    logic [21:0] rs;
    logic [21:0] re;
    int          n201;

    // Reset state
    xr = 1'b0;
    repeat (3) step();
    chk("rst_req", 32'(dma_req), 32'd0);
    chk("rst_addr", 32'(dma_addr), 32'd0);
    chk("rst_l", 32'(sample_l), 32'd0);
    chk("rst_r", 32'(sample_r), 32'd0);
    chk("rst_int", 32'(snd_int), 32'd0);
    chk("rst_cnt", 32'(cnt_addr), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    xr = 1'b1;
    step();

    // Stereo frame with exact timing
    model_clear();
    model_on = 1; fixed = 1; fixed_val = 16'h7F80; lat = 2;
    frame_start = 22'h100; frame_end = 22'h104; cur_end = 22'h104; snd_loop = 1'b0;
    snd_en = 1'b1;
    step();
    chk("load_active", 32'(active), 32'd1);
    chk("load_no_req", 32'(dma_req), 32'd0);
    step();
    chk("first_req", 32'(dma_req), 32'd1);
    chk("first_addr", 32'(dma_addr), 32'h100);
    for (int g = 0; g < 40 && !(acks == 4 && !dma_ack); g++) step();
    step();
    chk("st_acks", 32'(acks), 32'd4);
    for (int k = 0; k < 4 && k < acks; k++) chk("st_addr", 32'(ack_log[k]), 32'h100 + 32'(k));
    chk("st_ints", 32'(ints), 32'd1);
    chk("st_drain_active", 32'(active), 32'd1);
    chk("st_pre_tick_l", 32'(sample_l), 32'd0);
    smp_tick = 1'b1;
    step();
    chk("st_l", 32'(sample_l), 32'h7F);
    chk("st_r", 32'(sample_r), 32'h80);
    repeat (3) step();
    smp_tick = 1'b0;
    chk("st_pops", 32'(pops), 32'd4);
    step();
    step();
    chk("st_idle", 32'(active), 32'd0);

    // Frame table
    vecs[0] = '{22'h100,    22'h104,    2, 4,  1};
    vecs[1] = '{22'h300,    22'h300,    1, 0,  1};
    vecs[2] = '{22'h3FFFFE, 22'h000001, 0, 3,  1};
    vecs[3] = '{22'h3FFFFF, 22'h000000, 3, 1,  1};
    vecs[4] = '{22'h050,    22'h05A,    1, 10, 1};
    vecs[5] = '{22'h010,    22'h011,    0, 1,  1};
    for (int i = 0; i < 6; i++) run_frame(vecs[i].s, vecs[i].e, vecs[i].lat, vecs[i].n, vecs[i].ni);

    // Loop mode
    stop_play();
    model_clear();
    model_on = 1; fixed = 0; lat = 1;
    frame_start = 22'h200; frame_end = 22'h202; cur_end = 22'h202; snd_loop = 1'b1;
    snd_en = 1'b1;
    for (int g = 0; g < 60; g++) begin
      smp_tick = g[0];
      step();
    end
    smp_tick = 1'b0;
    chk("loop_n", 32'(ack_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < ack_log.size(); k++)
      chk("loop_addr", 32'(ack_log[k]), k[0] ? 32'h201 : 32'h200);
    n201 = 0;
    foreach (ack_log[k]) if (ack_log[k] == 22'h201) n201++;
    if (dma_ack && dma_addr == 22'h201) n201--;
    chk("loop_ints", 32'(ints), 32'(n201));
    chk("loop_active", 32'(active), 32'd1);
    snd_loop = 1'b0;

    // Mono byte phase
    stop_play();
    model_clear();
    model_on = 0; fixed = 1; fixed_val = 16'h1234; lat = 1; mono = 1'b1;
    frame_start = 22'h400; frame_end = 22'h401; cur_end = 22'h401;
    snd_en = 1'b1;
    wait_ack(22'h400);
    step();
    chk("mono_drain", 32'(active), 32'd1);
    smp_tick = 1'b1;
    step();
    smp_tick = 1'b0;
`ifdef GSTMCU_SND_MONO_EN
    chk("mono_l1", 32'(sample_l), 32'h12);
    chk("mono_r1", 32'(sample_r), 32'h12);
    step();
    chk("mono_held", 32'(active), 32'd1);
    smp_tick = 1'b1;
    step();
    smp_tick = 1'b0;
    chk("mono_l2", 32'(sample_l), 32'h34);
    chk("mono_r2", 32'(sample_r), 32'h34);
`else
    chk("mono_off_l", 32'(sample_l), 32'h12);
    chk("mono_off_r", 32'(sample_r), 32'h34);
`endif
    step();
    step();
    chk("mono_done", 32'(active), 32'd0);
    mono = 1'b0;

    // Backpressure: no ticks fills the FIFO, one tick frees one slot
    stop_play();
    model_clear();
    model_on = 1; fixed = 0; lat = 0;
    frame_start = 22'h500; frame_end = 22'h520; cur_end = 22'h520;
    snd_en = 1'b1;
    repeat (30) step();
    chk("bp_acks", 32'(acks), 32'd4);
    chk("bp_req", 32'(dma_req), 32'd0);
    smp_tick = 1'b1;
    step();
    smp_tick = 1'b0;
    repeat (5) step();
    chk("bp_acks2", 32'(acks), 32'd5);
    chk("bp_req2", 32'(dma_req), 32'd0);

    // Underrun: tick with an empty FIFO leaves samples alone
    stop_play();
    model_clear();
    lat = 6;
    frame_start = 22'h600; frame_end = 22'h610; cur_end = 22'h610;
    snd_en = 1'b1;
    wait_ack(22'h600);
    step();
    smp_tick = 1'b1;
    step();
    w = memw(22'h600);
    chk("ur_l0", 32'(sample_l), 32'(w[15:8]));
    step();
    smp_tick = 1'b0;
    chk("ur_l", 32'(sample_l), 32'(w[15:8]));
    chk("ur_r", 32'(sample_r), 32'(w[7:0]));

    // Stop coinciding with an ack
    stop_play();
    model_clear();
    lat = 2;
    frame_start = 22'h700; frame_end = 22'h710; cur_end = 22'h710;
    snd_en = 1'b1;
    wait_ack(22'h700);
    step();
    smp_tick = 1'b1;
    step();
    smp_tick = 1'b0;
    wait_ack(22'h702);
    snd_en = 1'b0;
    step();
    chk("stop_active", 32'(active), 32'd0);
    chk("stop_req", 32'(dma_req), 32'd0);
    chk("stop_l", 32'(sample_l), 32'd0);
    chk("stop_r", 32'(sample_r), 32'd0);
    chk("stop_cnt", 32'(cnt_addr), 32'h702);

    // Randomized frames
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) rs = 22'h3FFFF8 + 22'($urandom_range(0, 7));
      else rs = 22'($urandom);
      re = rs + 22'($urandom_range(1, 12));
      run_frame(rs, re, $urandom_range(0, 3), int'(22'(re - rs)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gst_snd_dma.md
# gst_snd_dma

DMA sound playback engine for the GSTMCU: the memory-reading side of the frame start/end address counters. It latches a frame window and fetches 16-bit words from RAM over a single-outstanding request/acknowledge bus. It buffers the words in a small FIFO and delivers signed 8-bit left/right samples on each sample-rate strobe. It raises a one-cycle end-of-frame pulse, which feeds the MFP timer-A/GPIP input.

## Interface
- `ADDR_W`, 22: word-address width (byte address bits 22:1).
- `FIFO_DEPTH`, 4: number of 16-bit words buffered; must be a power of two.
- `c` in 1: clock. One clock domain only.
- `xr` in 1: reset, synchronous, active-low.
- `snd_en` in 1: play enable (control register bit 0).
- `snd_loop` in 1: repeat frame (control register bit 1).
- `mono` in 1: 1 = mono (one byte per sample), 0 = stereo (high byte L, low byte R).
- `frame_start` in ADDR_W: first word of the frame.
- `frame_end` in ADDR_W: end word of the frame, exclusive.
- `smp_tick` in 1: one-cycle sample-rate strobe.
- `dma_req` out 1: word read request.
- `dma_addr` out ADDR_W: address of the requested word.
- `dma_ack` in 1: one-cycle pulse; `dma_data` is valid in that cycle.
- `dma_data` in 16: read data.
- `sample_l`, `sample_r` out 8: signed sample outputs.
- `snd_int` out 1: one-cycle end-of-frame pulse.
- `cnt_addr` out ADDR_W: live frame counter, for register readback.
- `active` out 1: high in LOAD, RUN and DRAIN.

## Operation
- Reset values of all outputs: 0. FIFO empty; state IDLE.
- **IDLE.** A rising edge of `snd_en` moves the block to LOAD.
- **LOAD**, one cycle:
  - `cnt_addr <= frame_start`; `end_q <= frame_end`.
  - If `frame_start == frame_end`: pulse `snd_int` and go to IDLE, regardless of `snd_loop`.
  - Otherwise go to RUN.
- **RUN, fetch side:**
  - Assert `dma_req` when FIFO count < `FIFO_DEPTH`, `cnt_addr != end_q`, and no request is outstanding.
  - `dma_addr = cnt_addr`.
  - Once asserted, `dma_req` and `dma_addr` hold until `dma_ack`.
- **RUN, on `dma_ack`:**
  - Push `dma_data` into the FIFO; `cnt_addr <= cnt_addr + 1`, wrapping at 2^ADDR_W.
  - If `cnt_addr + 1 == end_q`, the frame is done: pulse `snd_int` in the next cycle.
  - If `snd_loop` is 1 in the ack cycle: reload `cnt_addr <= frame_start` and `end_q <= frame_end`, then stay in RUN.
  - Otherwise go to DRAIN.
- **DRAIN.** No requests. When the FIFO is empty and no sample word is partially consumed, go to IDLE.
- **Playback**, in RUN and DRAIN, on `smp_tick`:
  - Stereo: pop one word; `sample_l <= word[15:8]`, `sample_r <= word[7:0]`.
  - Mono: the first tick outputs `word[15:8]` to both channels; the second tick outputs `word[7:0]` to both channels and pops.
  - FIFO empty on a tick (underrun): samples hold their values and the mono byte phase does not advance.
- **Simultaneous push and pop:** both take effect and the FIFO count is unchanged. A push is never lost, because a request is only issued when a slot is free.
- **Stop.** `snd_en` low in any state forces IDLE in the next cycle:
  - FIFO flushed, mono phase cleared, `sample_l`/`sample_r` set to 0, `dma_req` set to 0.
  - A `dma_ack` in the same cycle as `snd_en` low is discarded.
- `frame_start`, `frame_end` and `snd_loop` changes during RUN take effect only at the next LOAD or loop reload.
- `end_q` comparison is equality only. A frame with `frame_end < frame_start` therefore runs through the address wrap.

## Timing
- `snd_en` rises at cycle N: LOAD at N+1, first `dma_req` at N+2.
- `dma_ack` at cycle M:
  - `cnt_addr` updated and word poppable at M+1.
  - Next `dma_req` no earlier than M+1.
  - `snd_int` at M+1 if that word ended the frame.
- `smp_tick` at cycle T: `sample_l`/`sample_r` update at T+1.
- `xr` low at any clock edge resets everything, including in mid-request. The memory arbiter tolerates the dropped request.

## Configuration
- `GSTMCU_SND_MONO_EN`:
  - Defined: mono mode is implemented as described.
  - Undefined: the `mono` port is ignored, the block always runs stereo, and the mono byte-phase logic is absent.

## Structure
- Package `gst_snd_pkg` holds:
  - The state enum (IDLE, LOAD, RUN, DRAIN).
  - `SND_ADDR_W = 22` and `SND_FIFO_DEPTH = 4`.
- Sub-module `gst_snd_fifo`: synchronous `FIFO_DEPTH`×16 FIFO with push/pop/count, reset by `xr`.
- FSM, address counter, request logic and sample mux live in `gst_snd_dma`.

## Test plan
- **Stereo frame.** start=0x100, end=0x104, stereo, data 0x7F80 at every ack, ack 2 cycles after each req, `snd_loop`=0 → 4 reqs at 0x100..0x103, one `snd_int` after the 0x103 ack; four ticks give L=0x7F, R=0x80; then IDLE, `active`=0.
- **Loop.** start=0x200, end=0x202, `snd_loop`=1 → req addresses 0x200, 0x201, 0x200, 0x201…; `snd_int` after each 0x201 ack; state stays RUN.
- **Mono.** Word 0x1234 with `GSTMCU_SND_MONO_EN` defined → tick 1 gives L=R=0x12, tick 2 gives L=R=0x34 and pops. With the macro undefined → L=0x12, R=0x34.
- **Backpressure and underrun.**
  - No ticks → exactly 4 acks, then `dma_req` stays 0.
  - One tick → one new req.
  - Empty FIFO plus tick → samples unchanged.
- **Stop mid-frame.** Drop `snd_en` in the same cycle as `dma_ack` → next cycle IDLE, `dma_req`=0, samples 0, `cnt_addr` not incremented.
- **Edge cases.**
  - start=end=0x300 → one `snd_int` in LOAD, no req.
  - start=0x3FFFFE, end=0x000001 → reqs at 0x3FFFFE, 0x3FFFFF, 0x000000.
